// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the iterative divider.
// The requester drives the operands; the divider returns status and results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             Div_start;
  logic             Div_signed;
  logic [WIDTH-1:0] Div_a;
  logic [WIDTH-1:0] Div_b;
  logic             Div_busy;
  logic             Div_done;
  logic [WIDTH-1:0] Div_q;
  logic [WIDTH-1:0] Div_r;
  logic             Div_dbz;

  modport master (
    output Div_start, Div_signed, Div_a, Div_b,
    input  Div_busy, Div_done, Div_q, Div_r, Div_dbz
  );

  modport slave (
    input  Div_start, Div_signed, Div_a, Div_b,
    output Div_busy, Div_done, Div_q, Div_r, Div_dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one shift/subtract/restore step per clock,
// signed handled by dividing magnitudes and fixing signs on the final step.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave div
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz_reg;

  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  assign b_zero = (div.Div_b == '0);
  assign a_mag  = (div.Div_signed && div.Div_a[WIDTH-1]) ? -div.Div_a : div.Div_a;
  assign b_mag  = (div.Div_signed && div.Div_b[WIDTH-1]) ? -div.Div_b : div.Div_b;

  // Shifted partial remainder is WIDTH+1 bits; the top bit of the difference
  // is the borrow that decides restore versus keep.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_step = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
  end

  assign q_fixed = neg_q ? -quo_step : quo_step;
  assign r_fixed = neg_r ? -rem_step : rem_step;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (div.Div_start) state_next = b_zero ? DONE : RUN;
      RUN:  if (cnt == '0)     state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    div.Div_busy = (state != IDLE);
    div.Div_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div.Div_start) begin
            neg_q   <= div.Div_signed & (div.Div_a[WIDTH-1] ^ div.Div_b[WIDTH-1]);
            neg_r   <= div.Div_signed & div.Div_a[WIDTH-1];
            divisor <= b_mag;
            quo     <= a_mag;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            // A zero divisor skips the iteration and reports immediately.
            if (b_zero) begin
              q_reg   <= '1;
              r_reg   <= div.Div_a;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= '0;
              r_reg   <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            q_reg <= q_fixed;
            r_reg <= r_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign div.Div_q   = q_reg;
  assign div.Div_r   = r_reg;
  assign div.Div_dbz = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W = 32;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) div ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .div (div)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (div.Div_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with q=%h r=%h, expected no pending result (t=%0t)",
                 div.Div_q, div.Div_r, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_q"},   div.Div_q,         e.q);
        check({e.name, "_r"},   div.Div_r,         e.r);
        check({e.name, "_dbz"}, W'(div.Div_dbz),   W'(e.dbz));
      end
    end
  end

  task automatic expect_res(input string name, input logic [W-1:0] q,
                            input logic [W-1:0] r, input logic dbz);
    exp_t e;
    e.name = name;
    e.q    = q;
    e.r    = r;
    e.dbz  = dbz;
    sb.push_back(e);
  endtask

  // Presents a start for one cycle; returns 1ns after the capture edge E0
  // with the operand inputs scrambled to prove they are not re-sampled.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    div.Div_start  = 1'b1;
    div.Div_signed = sgn;
    div.Div_a      = a;
    div.Div_b      = b;
    @(posedge clk);
    #1;
    div.Div_start  = 1'b0;
    div.Div_signed = 1'($urandom);
    div.Div_a      = $urandom;
    div.Div_b      = $urandom;
  endtask

  // Counts edges until done, checks latency, pulse width and busy span.
  task automatic wait_done(input string name, input int exp_lat);
    int lat      = 0;
    int busy_cnt = 0;
    busy_cnt += int'(div.Div_busy === 1'b1);
    while (div.Div_done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      busy_cnt += int'(div.Div_busy === 1'b1);
    end
    check({name, "_latency"}, W'(lat), W'(exp_lat));
    @(posedge clk);
    #1;
    busy_cnt += int'(div.Div_busy === 1'b1);
    check({name, "_done_pulse_1cyc"}, W'(div.Div_done), W'(0));
    check({name, "_busy_cycles"},     W'(busy_cnt),     W'(exp_lat + 1));
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] q,
                        input logic [W-1:0] r, input logic dbz, input int lat);
    expect_res(name, q, r, dbz);
    issue(sgn, a, b);
    wait_done(name, lat);
  endtask

  initial begin
    rst            = 1'b1;
    div.Div_start  = 1'b0;
    div.Div_signed = 1'b0;
    div.Div_a      = '0;
    div.Div_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(div.Div_busy), W'(0));
    check("reset_done", W'(div.Div_done), W'(0));
    check("reset_q",    div.Div_q,        W'(0));
    check("reset_r",    div.Div_r,        W'(0));
    check("reset_dbz",  W'(div.Div_dbz),  W'(0));
    rst = 1'b0;

    run_op("u_100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32);
    run_op("s_m7_2",       1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 32);
    run_op("s_7_m2",       1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 32);
    run_op("u_max_16",     1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0, 32);
    run_op("s_m100_m7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 32);
    run_op("u_msb_max",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 32);
    run_op("u_dbz_5",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0);
    run_op("s_dbz_m9",     1'b1, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF7,  1'b1, 0);
    run_op("s_overflow",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 32);

    // Start re-pulsed at E10 while running must not disturb the operation.
    expect_res("busy_start", 32'd14, 32'd2, 1'b0);
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div.Div_start = 1'b1;
    div.Div_a     = 32'd9;
    div.Div_b     = 32'd3;
    @(posedge clk);
    #1;
    div.Div_start = 1'b0;
    wait_done("busy_start", 22);
    run_op("back_to_back", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

    // Reset at E10 aborts the divide with no done pulse.
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", W'(div.Div_busy), W'(0));
    check("abort_q",    div.Div_q,        W'(0));
    check("abort_r",    div.Div_r,        W'(0));
    repeat (40) @(posedge clk);
    run_op("after_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
